// File: rtl/calc_ctrl_if.sv
// Keypad, ALU handshake and display signals of the calculator controller.
// The controller connects through the slave modport, its environment through master.
interface calc_ctrl_if #(
    parameter int DIGIT_NUM = 8,
    parameter int BRIGHT_W  = 4
);
    logic                     key_valid;
    logic                     key_type;
    logic [3:0]               key;
    logic                     alu_start;
    logic [2:0]               alu_op;
    logic [4*DIGIT_NUM-1:0]   alu_a;
    logic [4*DIGIT_NUM-1:0]   alu_b;
    logic                     alu_a_sign;
    logic                     alu_b_sign;
    logic                     alu_done;
    logic [4*DIGIT_NUM-1:0]   alu_result;
    logic                     alu_result_sign;
    logic                     alu_error;
    logic [4*DIGIT_NUM-1:0]   disp_value;
    logic                     disp_sign;
    logic                     disp_error;
    logic [BRIGHT_W-1:0]      brightness;
    logic [2:0]               state;

    modport slave (
        input  key_valid, key_type, key,
        input  alu_done, alu_result, alu_result_sign, alu_error,
        output alu_start, alu_op, alu_a, alu_b, alu_a_sign, alu_b_sign,
        output disp_value, disp_sign, disp_error, brightness, state
    );

    modport master (
        output key_valid, key_type, key,
        output alu_done, alu_result, alu_result_sign, alu_error,
        input  alu_start, alu_op, alu_a, alu_b, alu_a_sign, alu_b_sign,
        input  disp_value, disp_sign, disp_error, brightness, state
    );
endinterface

// File: rtl/calc_ctrl.sv
// Calculator front-end: keypad entry of two BCD operands, op selection, ALU
// request/response handshake with timeout, error state and display brightness.
module calc_ctrl #(
    parameter int DIGIT_NUM    = 8,
    parameter int BRIGHT_W     = 4,
    parameter int BRIGHT_RESET = 8,
    parameter int ALU_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    calc_ctrl_if.slave bus
);
    localparam int OW = 4 * DIGIT_NUM;
    localparam int TW = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ALU_TIMEOUT - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_EXP = 3'b100;

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        ALT_A    = 3'd2,
        ALT_B    = 3'd3,
        WAIT_ALU = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t              state_q;
    state_t              tgt_q;
    logic [OW-1:0]       a_q;
    logic [OW-1:0]       b_q;
    logic                a_sign_q;
    logic                b_sign_q;
    logic [2:0]          op_q;
    logic [2:0]          pend_q;
    logic                b_ent_q;
    logic                fresh_q;
    logic                err_q;
    logic                alu_start_q;
    logic                key_prev_q;
    logic [TW-1:0]       timer_q;
    logic [BRIGHT_W-1:0] bright_q;

    logic                key_hit;
    logic                is_digit;
    logic                is_sym;
    logic                k_add;
    logic                k_sub;
    logic                k_clr;
    logic                k_eq;
    logic                k_cyc;
    logic                k_alt;
    logic                a_full;
    logic                b_full;
    logic                a_zero;
    logic                b_zero;
    logic                issue_req;
    logic [2:0]          issue_pend;
    state_t              issue_tgt;
    logic [2:0]          cyc_op;
    logic [OW-1:0]       a_shift;
    logic [OW-1:0]       b_shift;
    logic [OW-1:0]       digit_only;
    logic [BRIGHT_W-1:0] bright_val;

    // A key counts only on its rising edge of key_valid, so held keys never repeat.
    assign key_hit  = bus.key_valid & ~key_prev_q;
    assign is_digit = key_hit & ~bus.key_type & (bus.key <= 4'd9);
    assign is_sym   = key_hit & bus.key_type & (bus.key >= 4'hA);
    assign k_add    = is_sym & (bus.key == 4'hA);
    assign k_sub    = is_sym & (bus.key == 4'hB);
    assign k_clr    = is_sym & (bus.key == 4'hC);
    assign k_eq     = is_sym & (bus.key == 4'hD);
    assign k_cyc    = is_sym & (bus.key == 4'hE);
    assign k_alt    = is_sym & (bus.key == 4'hF);

    assign a_full     = (a_q[OW-1 -: 4] != 4'd0);
    assign b_full     = (b_q[OW-1 -: 4] != 4'd0);
    assign a_zero     = (a_q == '0);
    assign b_zero     = (b_q == '0);
    assign a_shift    = {a_q[OW-5:0], bus.key};
    assign b_shift    = {b_q[OW-5:0], bus.key};
    assign digit_only = {{(OW-4){1'b0}}, bus.key};
    assign bright_val = BRIGHT_W'({bus.key, 1'b0});

    always_comb begin
        cyc_op = OP_MUL;
        if (op_q == OP_MUL) begin
            cyc_op = OP_DIV;
        end else if (op_q == OP_DIV) begin
            cyc_op = OP_EXP;
        end
    end

    // An op key with a nonzero B chains: it issues now and becomes the op applied afterwards.
    assign issue_req = (state_q == LOAD_B) && !b_zero && (k_add || k_sub || k_cyc || k_eq);

    always_comb begin
        issue_pend = op_q;
        issue_tgt  = LOAD_B;
        if (k_add) begin
            issue_pend = OP_ADD;
        end else if (k_sub) begin
            issue_pend = OP_SUB;
        end else if (k_cyc) begin
            issue_pend = OP_MUL;
        end else if (k_eq) begin
            issue_tgt = LOAD_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            tgt_q       <= LOAD_A;
            a_q         <= '0;
            b_q         <= '0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            op_q        <= OP_ADD;
            pend_q      <= OP_ADD;
            b_ent_q     <= 1'b0;
            fresh_q     <= 1'b0;
            err_q       <= 1'b0;
            alu_start_q <= 1'b0;
            key_prev_q  <= 1'b1;
            timer_q     <= '0;
            bright_q    <= BRIGHT_W'(BRIGHT_RESET);
        end else begin
            key_prev_q  <= bus.key_valid;
            alu_start_q <= 1'b0;
            // A returning result wins over any key arriving on the same cycle.
            if (state_q == WAIT_ALU && bus.alu_done) begin
                if (bus.alu_error) begin
                    state_q <= ERROR;
                    err_q   <= 1'b1;
                end else begin
                    a_q      <= bus.alu_result;
                    a_sign_q <= bus.alu_result_sign;
                    b_q      <= '0;
                    b_sign_q <= 1'b0;
                    b_ent_q  <= 1'b0;
                    op_q     <= pend_q;
                    fresh_q  <= (tgt_q == LOAD_A);
                    state_q  <= tgt_q;
                end
            end else if (k_clr) begin
                state_q  <= LOAD_A;
                a_q      <= '0;
                b_q      <= '0;
                a_sign_q <= 1'b0;
                b_sign_q <= 1'b0;
                op_q     <= OP_ADD;
                pend_q   <= OP_ADD;
                b_ent_q  <= 1'b0;
                fresh_q  <= 1'b0;
                err_q    <= 1'b0;
                timer_q  <= '0;
            end else begin
                case (state_q)
                    LOAD_A: begin
                        if (is_digit) begin
                            fresh_q <= 1'b0;
                            if (fresh_q) begin
                                a_q      <= digit_only;
                                a_sign_q <= 1'b0;
                            end else if (!a_full) begin
                                a_q <= a_shift;
                            end
                        end else if (k_add || k_sub) begin
                            fresh_q <= 1'b0;
                            if (a_zero) begin
                                a_sign_q <= ~a_sign_q;
                            end else begin
                                op_q     <= k_sub ? OP_SUB : OP_ADD;
                                b_q      <= '0;
                                b_sign_q <= 1'b0;
                                b_ent_q  <= 1'b0;
                                state_q  <= LOAD_B;
                            end
                        end else if (k_cyc) begin
                            fresh_q <= 1'b0;
                            if (!a_zero) begin
                                op_q     <= OP_MUL;
                                b_q      <= '0;
                                b_sign_q <= 1'b0;
                                b_ent_q  <= 1'b0;
                                state_q  <= LOAD_B;
                            end
                        end else if (k_alt) begin
                            state_q <= ALT_A;
                        end
                    end
                    LOAD_B: begin
                        if (issue_req) begin
                            alu_start_q <= 1'b1;
                            pend_q      <= issue_pend;
                            tgt_q       <= issue_tgt;
                            timer_q     <= '0;
                            state_q     <= WAIT_ALU;
                        end else if (is_digit) begin
                            b_ent_q <= 1'b1;
                            if (!b_full) begin
                                b_q <= b_shift;
                            end
                        end else if (k_add || k_sub) begin
                            b_sign_q <= ~b_sign_q;
                            b_ent_q  <= 1'b1;
                        end else if (k_cyc) begin
                            op_q <= cyc_op;
                        end else if (k_alt) begin
                            state_q <= ALT_B;
                        end
                    end
                    ALT_A, ALT_B: begin
                        if (is_digit && bus.key <= 4'd7) begin
                            bright_q <= bright_val;
                        end else if (k_alt) begin
                            state_q <= (state_q == ALT_A) ? LOAD_A : LOAD_B;
                        end
                    end
                    WAIT_ALU: begin
                        if (timer_q == TIMER_LAST) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    ERROR: begin
                    end
                    default: begin
                        state_q <= LOAD_A;
                    end
                endcase
            end
        end
    end

    // B is only shown once the user has started typing it or changed its sign.
    always_comb begin
        bus.disp_value = a_q;
        bus.disp_sign  = a_sign_q;
        if (state_q == ERROR) begin
            bus.disp_value = '0;
            bus.disp_sign  = 1'b0;
        end else if ((state_q == LOAD_B || state_q == ALT_B) && b_ent_q) begin
            bus.disp_value = b_q;
            bus.disp_sign  = b_sign_q;
        end
    end

    assign bus.disp_error = err_q;
    assign bus.brightness = bright_q;
    assign bus.state      = state_q;
    assign bus.alu_start  = alu_start_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_a_sign = a_sign_q;
    assign bus.alu_b_sign = b_sign_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed scenarios plus random keypad/ALU
// traffic compared against a decimal-arithmetic model of the calculator.
module tb_calc_ctrl;
    localparam int DN        = 8;
    localparam int TIMEOUT   = 1024;
    localparam longint LIMIT = 64'd10000000;

    localparam int S_LA = 0;
    localparam int S_LB = 1;
    localparam int S_AA = 2;
    localparam int S_AB = 3;
    localparam int S_W  = 4;
    localparam int S_E  = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    calc_ctrl_if #(.DIGIT_NUM(DN), .BRIGHT_W(4)) bus ();

    calc_ctrl #(
        .DIGIT_NUM(DN),
        .BRIGHT_W(4),
        .BRIGHT_RESET(8),
        .ALU_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: operands held as plain decimal numbers.
    int     mState;
    longint mA;
    longint mB;
    bit     mAs;
    bit     mBs;
    int     mOp;
    int     mPend;
    int     mTgt;
    bit     mFresh;
    bit     mBEnt;
    bit     mErr;
    int     mBright;

    function automatic logic [4*DN-1:0] toBcd(input longint v);
        logic [4*DN-1:0] r;
        longint t;
        r = '0;
        t = v;
        for (int i = 0; i < DN; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        mState = S_LA;
        mA = 0;
        mB = 0;
        mAs = 0;
        mBs = 0;
        mOp = 0;
        mPend = 0;
        mTgt = S_LA;
        mFresh = 0;
        mBEnt = 0;
        mErr = 0;
    endtask

    task automatic modelKey(input bit kt, input int kc, output bit issued);
        bit dig;
        bit sym;
        issued = 0;
        dig = !kt && kc <= 9;
        sym = kt && kc >= 10;
        if (sym && kc == 12) begin
            modelClear();
            return;
        end
        case (mState)
            S_LA: begin
                if (dig) begin
                    if (mFresh) begin
                        mA = kc;
                        mAs = 0;
                    end else if (mA < LIMIT) begin
                        mA = mA * 10 + kc;
                    end
                    mFresh = 0;
                end else if (sym && (kc == 10 || kc == 11 || kc == 14)) begin
                    mFresh = 0;
                    if (mA == 0) begin
                        if (kc != 14) mAs = !mAs;
                    end else begin
                        mOp = (kc == 10) ? 0 : (kc == 11) ? 1 : 2;
                        mB = 0;
                        mBs = 0;
                        mBEnt = 0;
                        mState = S_LB;
                    end
                end else if (sym && kc == 15) begin
                    mState = S_AA;
                end
            end
            S_LB: begin
                if (dig) begin
                    mBEnt = 1;
                    if (mB < LIMIT) mB = mB * 10 + kc;
                end else if (sym && kc >= 10 && kc <= 14) begin
                    if (mB != 0) begin
                        issued = 1;
                        mPend = (kc == 10) ? 0 : (kc == 11) ? 1 : (kc == 14) ? 2 : mOp;
                        mTgt = (kc == 13) ? S_LA : S_LB;
                        mState = S_W;
                    end else if (kc == 14) begin
                        mOp = (mOp == 2) ? 3 : (mOp == 3) ? 4 : 2;
                    end else if (kc == 10 || kc == 11) begin
                        mBs = !mBs;
                        mBEnt = 1;
                    end
                end else if (sym && kc == 15) begin
                    mState = S_AB;
                end
            end
            S_AA, S_AB: begin
                if (dig && kc <= 7) begin
                    mBright = (2 * kc) % 16;
                end else if (sym && kc == 15) begin
                    mState = (mState == S_AA) ? S_LA : S_LB;
                end
            end
            default: begin
            end
        endcase
    endtask

    task automatic checkState();
        longint dv;
        bit ds;
        dv = mA;
        ds = mAs;
        if (mState == S_E) begin
            dv = 0;
            ds = 0;
        end else if ((mState == S_LB || mState == S_AB) && mBEnt) begin
            dv = mB;
            ds = mBs;
        end
        checkOutput("state", bus.state, mState);
        checkOutput("disp_value", bus.disp_value, toBcd(dv));
        checkOutput("disp_sign", bus.disp_sign, ds);
        checkOutput("disp_error", bus.disp_error, mErr);
        checkOutput("brightness", bus.brightness, mBright);
    endtask

    task automatic applyStimulus(input bit kt, input int kc);
        bit issued;
        modelKey(kt, kc, issued);
        bus.key_type = kt;
        bus.key = 4'(kc);
        bus.key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("alu_start", bus.alu_start, issued);
        if (issued) begin
            checkOutput("alu_op", bus.alu_op, mOp);
            checkOutput("alu_a", bus.alu_a, toBcd(mA));
            checkOutput("alu_b", bus.alu_b, toBcd(mB));
            checkOutput("alu_a_sign", bus.alu_a_sign, mAs);
            checkOutput("alu_b_sign", bus.alu_b_sign, mBs);
        end
        bus.key_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("alu_start_pulse", bus.alu_start, 1'b0);
        checkState();
    endtask

    task automatic aluRespond(input int delay, input longint res, input bit sgn, input bit err,
                              input bit withKey, input bit kt, input int kc);
        bit dummy;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("start_idle", bus.alu_start, 1'b0);
            if (mState == S_W) checkOutput("alu_a_hold", bus.alu_a, toBcd(mA));
        end
        bus.alu_done = 1'b1;
        bus.alu_result = toBcd(res);
        bus.alu_result_sign = sgn;
        bus.alu_error = err;
        if (withKey) begin
            bus.key_type = kt;
            bus.key = 4'(kc);
            bus.key_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.alu_error = 1'b0;
        bus.key_valid = 1'b0;
        if (mState == S_W) begin
            if (err) begin
                mState = S_E;
                mErr = 1;
            end else begin
                mA = res;
                mAs = sgn;
                mB = 0;
                mBs = 0;
                mBEnt = 0;
                mOp = mPend;
                mFresh = (mTgt == S_LA);
                mState = mTgt;
            end
        end else if (withKey) begin
            modelKey(kt, kc, dummy);
        end
        @(posedge clk);
        @(negedge clk);
        checkState();
    endtask

    task automatic doReset(input bit holdKey);
        rst_n = 1'b0;
        bus.key_valid = holdKey;
        bus.key_type = 1'b0;
        bus.key = 4'd5;
        bus.alu_done = 1'b0;
        repeat (2) @(negedge clk);
        modelClear();
        mBright = 8;
        checkOutput("rst_state", bus.state, S_LA);
        checkOutput("rst_disp", bus.disp_value, 0);
        checkOutput("rst_bright", bus.brightness, 8);
        checkOutput("rst_start", bus.alu_start, 1'b0);
        checkOutput("rst_op", bus.alu_op, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkState();
    endtask

    task automatic randomKey();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) applyStimulus(1'b0, $urandom_range(0, 9));
        else if (r < 55) applyStimulus(1'b0, $urandom_range(10, 15));
        else if (r < 58) applyStimulus(1'b1, $urandom_range(0, 9));
        else if (r < 68) applyStimulus(1'b1, 10);
        else if (r < 76) applyStimulus(1'b1, 11);
        else if (r < 79) applyStimulus(1'b1, 12);
        else if (r < 88) applyStimulus(1'b1, 13);
        else if (r < 94) applyStimulus(1'b1, 14);
        else applyStimulus(1'b1, 15);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_type = 1'b0;
        bus.key = 4'd0;
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        bus.alu_result_sign = 1'b0;
        bus.alu_error = 1'b0;
        doReset(1'b0);

        // Digit entry and held-key suppression.
        applyStimulus(1'b0, 1);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b0, 3);
        checkOutput("entry_123", bus.disp_value, 32'h00000123);
        begin
            bit dummy;
            modelKey(1'b0, 4, dummy);
            bus.key_type = 1'b0;
            bus.key = 4'd4;
            bus.key_valid = 1'b1;
            repeat (10) @(negedge clk);
            bus.key_valid = 1'b0;
            @(negedge clk);
            checkOutput("held_key", bus.disp_value, 32'h00001234);
            checkState();
        end

        // Full operand ignores further digits.
        applyStimulus(1'b1, 12);
        for (int d = 1; d <= 9; d++) applyStimulus(1'b0, d);
        checkOutput("full_operand", bus.disp_value, 32'h12345678);

        // 12 + 5 = with a delayed result.
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 13);
        aluRespond(3, 17, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("equals_disp", bus.disp_value, 32'h17);
        checkOutput("equals_state", bus.state, S_LA);

        // Sign toggle on zero operand, then chained subtraction.
        applyStimulus(1'b1, 12);
        applyStimulus(1'b1, 10);
        checkOutput("neg_sign", bus.disp_sign, 1'b1);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 7);
        applyStimulus(1'b1, 11);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 11);
        aluRespond(1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("chain_state", bus.state, S_LB);
        checkOutput("chain_op", bus.alu_op, 3'b001);

        // ALU never answers: timeout lands exactly after TIMEOUT waiting cycles.
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 13);
        repeat (TIMEOUT - 2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("before_timeout", bus.state, S_W);
        @(posedge clk);
        @(negedge clk);
        mState = S_E;
        mErr = 1;
        checkState();
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 12);

        // Clear aborts a pending request; a late result is ignored.
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 13);
        applyStimulus(1'b1, 12);
        aluRespond(1, 55, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Result and clear key on the same cycle: the result wins.
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 13);
        aluRespond(1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 12);
        checkOutput("collide_disp", bus.disp_value, 32'h3);

        // Brightness menu, then reset in the middle of entry with a key held.
        applyStimulus(1'b1, 15);
        applyStimulus(1'b0, 5);
        checkOutput("bright_10", bus.brightness, 10);
        applyStimulus(1'b1, 15);
        applyStimulus(1'b0, 4);
        doReset(1'b1);

        // Random traffic against the model.
        for (int it = 0; it < 500; it++) begin
            if (mState == S_W && $urandom_range(0, 9) < 8) begin
                aluRespond($urandom_range(0, 4), longint'($urandom_range(0, 99999999)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                           1'b0, 1'b0, 0);
            end else begin
                randomKey();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_NUM, default 8, number of BCD digits per operand.
REQ-002 SHALL have parameter BRIGHT_W, default 4, brightness output width.
REQ-003 SHALL have parameter BRIGHT_RESET, default 8, brightness value after reset.
REQ-004 SHALL have parameter ALU_TIMEOUT, default 1024, maximum cycles waited for alu_done.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-006 key_valid  in  1  keypad press valid, held high while a key is down.
REQ-007 key_type  in  1  0 = number key, 1 = symbol key.
REQ-008 key  in  4  key code: 0-9 digits; A add, B subtract, C clear, D equals, E cycle op, F alt menu.
REQ-009 alu_start  out  1  one-cycle request pulse; alu_op  out  3  op code (000 add, 001 sub, 010 mul, 011 div, 100 exp).
REQ-010 alu_a, alu_b  out  4*DIGIT_NUM  BCD operands; alu_a_sign, alu_b_sign  out  1  1 = negative.
REQ-011 alu_done  in  1  result valid pulse; alu_result  in  4*DIGIT_NUM; alu_result_sign  in  1; alu_error  in  1, qualified by alu_done.
REQ-012 disp_value  out  4*DIGIT_NUM; disp_sign  out  1; disp_error  out  1; brightness  out  BRIGHT_W; state  out  3 (debug).

Function
REQ-013 SHALL accept a key only on the cycle where key_valid is high and was low the previous cycle; held keys SHALL NOT repeat.
REQ-014 States (state encoding): LOAD_A 0, LOAD_B 1, ALT_A 2, ALT_B 3, WAIT_ALU 4, ERROR 5; other codes SHALL return to LOAD_A.
REQ-015 Digit 0-9 in LOAD_A/LOAD_B SHALL shift the active operand left 4 bits and insert the digit at [3:0]; number codes >9 ignored.
REQ-016 Digit SHALL be ignored when the active operand's top digit is nonzero (DIGIT_NUM digits full); leading zeros keep the operand at 0.
REQ-017 After an equals result, the first digit in LOAD_A SHALL clear operand A and sign before inserting.
REQ-018 A/B in LOAD_A with A==0 SHALL toggle A sign; with A!=0 SHALL set op add/sub and go LOAD_B with B=0, sign 0.
REQ-019 E in LOAD_A with A!=0 SHALL set op mul, then cycle mul->div->exp->mul on repeated E in LOAD_B while B==0.
REQ-020 A/B in LOAD_B with B==0 SHALL toggle B sign (E per REQ-019); with B!=0 SHALL issue the current op, store add/sub/mul as pending op, and return to LOAD_B after the result.
REQ-021 D in LOAD_B with B!=0 SHALL issue the current op and return to LOAD_A after the result; D elsewhere ignored.
REQ-022 Issuing SHALL register alu_start=1 on the accepting edge, deassert it next edge, enter WAIT_ALU, and hold alu_a/alu_b/signs/op stable until exit.
REQ-023 In WAIT_ALU, alu_done with alu_error=0 SHALL load alu_result/sign into A, clear B, and go to the target state of REQ-020/021 next edge.
REQ-024 alu_done with alu_error=1, or ALU_TIMEOUT cycles without alu_done, SHALL enter ERROR with disp_error=1.
REQ-025 In WAIT_ALU all keys except C SHALL be ignored; alu_done outside WAIT_ALU SHALL be ignored.
REQ-026 C in any state SHALL clear A, B, signs, op, error and go LOAD_A; C in WAIT_ALU aborts and a later alu_done is ignored.
REQ-027 In ERROR only C SHALL be accepted.
REQ-028 F SHALL toggle LOAD_A<->ALT_A and LOAD_B<->ALT_B, operands preserved.
REQ-029 Digit k<=7 in ALT states SHALL set brightness = 2*k truncated to BRIGHT_W bits; k>7 ignored.
REQ-030 disp_value/sign SHALL show B in LOAD_B/ALT_B once a B digit or sign change was entered, otherwise A; ERROR shows 0.
REQ-031 Simultaneous accepted key and alu_done SHALL process alu_done; the key is dropped.

Reset
REQ-032 While reset is low: state LOAD_A, operands/signs 0, op add, alu_start 0, disp outputs 0, brightness BRIGHT_RESET, edge detector primed with previous key_valid = 1.
REQ-033 Reset deassertion mid-WAIT_ALU SHALL NOT produce alu_start; pending alu_done SHALL be ignored.

Verification
REQ-034 Keys 1,2,3 (separate presses) -> disp_value 0x00000123; key 4 held 10 cycles -> exactly one digit entered.
REQ-035 Enter 12345678, then 9 -> value stays 0x12345678.
REQ-036 12, A, 5, D; alu_done result 0x17 after 3 cycles -> one alu_start pulse, alu_op 000, alu_a 0x12, alu_b 0x5, LOAD_A, disp 0x17.
REQ-037 A in LOAD_A with A=0 -> disp_sign 1; 7, B, 3, B -> sub issued, result in A, state LOAD_B, op sub.
REQ-038 Issue op, no alu_done for ALU_TIMEOUT cycles -> ERROR, disp_error 1; digit ignored; C -> LOAD_A, all clear.
REQ-039 F, 5 -> brightness 10, state ALT_A; F -> LOAD_A, operand unchanged; reset low mid-entry -> brightness 8, operands 0.
